// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage 8-bit core.
// Produces PC/IFID/IDEX stall and IFID/IDEX/EXMEM flush controls for load-use,
// multi-cycle MUL and taken-branch squash, plus the EX operand forwarding selects.
// Optional build macro HAZ_STATS_EN adds the saturating STALL_CNT/FLUSH_CNT outputs.
module hazard_ctrl #(
  parameter logic [4:0]  OP_NOP     = 5'h1f,
  parameter logic [4:0]  OP_LOAD    = 5'h10,
  parameter logic [4:0]  OP_MUL     = 5'h08,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] IFID_R1_ADDR,
  input  logic [3:0] IFID_R2_ADDR,
  input  logic [4:0] IDEX_OPCODE,
  input  logic [2:0] IDEX_RD_ADDR,
  input  logic [3:0] IDEX_R1_ADDR,
  input  logic [3:0] IDEX_R2_ADDR,
  input  logic [2:0] EXMEM_RD_ADDR,
  input  logic       EXMEM_WE,
  input  logic [2:0] MEMWB_RD_ADDR,
  input  logic       MEMWB_WE,
  input  logic       BR_TAKEN,
  output logic       PC_STALL,
  output logic       IFID_STALL,
  output logic       IDEX_STALL,
  output logic       IFID_FLUSH,
  output logic       IDEX_FLUSH,
  output logic       EXMEM_FLUSH,
  output logic       MUL_DONE,
  output logic [1:0] FWD_A,
  output logic [1:0] FWD_B
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT
`endif
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  // Remaining wait cycles loaded when a MUL first reaches EX; the final EX
  // cycle is the MUL_WAIT cycle with cnt==0.
  localparam logic [3:0] MUL_LOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // A bubble never starts a hazard, even if an opcode parameter collides with it.
  logic ex_is_load, ex_is_mul, load_use;
  assign ex_is_load = (IDEX_OPCODE == OP_LOAD) && (IDEX_OPCODE != OP_NOP);
  assign ex_is_mul  = (IDEX_OPCODE == OP_MUL)  && (IDEX_OPCODE != OP_NOP);

  // An ID source with bit3 set is an immediate and never conflicts.
  function automatic logic src_hit(input logic [3:0] src, input logic [2:0] rd);
    return !src[3] && (src[2:0] == rd);
  endfunction

  assign load_use = ex_is_load &&
                    (src_hit(IFID_R1_ADDR, IDEX_RD_ADDR) || src_hit(IFID_R2_ADDR, IDEX_RD_ADDR));

  // EXMEM is the younger producer, so it takes priority over MEMWB.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                         input logic       ex_we, input logic [2:0] ex_rd,
                                         input logic       wb_we, input logic [2:0] wb_rd);
    if (src[3])                           return 2'b00;
    else if (ex_we && (src[2:0] == ex_rd)) return 2'b01;
    else if (wb_we && (src[2:0] == wb_rd)) return 2'b10;
    else                                  return 2'b00;
  endfunction

  // State register and MUL wait counter; synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall/flush decode, priority branch > MUL > load-use.
  always_comb begin
    // NOTE: every output is defaulted first so no path leaves a value held,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    PC_STALL    = 1'b0;
    IFID_STALL  = 1'b0;
    IDEX_STALL  = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    MUL_DONE    = 1'b0;
    if (!rst) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else if (BR_TAKEN) begin
      // Squash the three younger instructions; any MUL in EX dies with them.
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      EXMEM_FLUSH = 1'b1;
      state_d     = RUN;
    end else if (state_q == MUL_WAIT) begin
      if (cnt_q != 4'd0) begin
        PC_STALL    = 1'b1;
        IFID_STALL  = 1'b1;
        IDEX_STALL  = 1'b1;
        EXMEM_FLUSH = 1'b1;
        cnt_d       = cnt_q - 4'd1;
      end else begin
        MUL_DONE = 1'b1;
        state_d  = RUN;
      end
    end else if (ex_is_mul) begin
      if (MUL_CYCLES > 1) begin
        PC_STALL    = 1'b1;
        IFID_STALL  = 1'b1;
        IDEX_STALL  = 1'b1;
        EXMEM_FLUSH = 1'b1;
        cnt_d       = MUL_LOAD;
        state_d     = MUL_WAIT;
      end else begin
        MUL_DONE = 1'b1;
      end
    end else if (load_use) begin
      PC_STALL   = 1'b1;
      IFID_STALL = 1'b1;
      IDEX_FLUSH = 1'b1;
    end
  end

  // Forwarding selects are independent of the FSM; forced to 00 while in reset.
  assign FWD_A = rst ? fwd_sel(IDEX_R1_ADDR, EXMEM_WE, EXMEM_RD_ADDR, MEMWB_WE, MEMWB_RD_ADDR) : 2'b00;
  assign FWD_B = rst ? fwd_sel(IDEX_R2_ADDR, EXMEM_WE, EXMEM_RD_ADDR, MEMWB_WE, MEMWB_RD_ADDR) : 2'b00;

`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of stalled-PC cycles and taken-branch cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (PC_STALL && (stall_cnt_q != 16'hffff)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (BR_TAKEN && (flush_cnt_q != 16'hffff)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic for hazard_ctrl.
// A behavioural model tracks how long the current MUL has occupied EX and
// derives every output from the sequencing rules; a negedge process compares
// it against the DUT each cycle.
module tb_hazard_ctrl;
  localparam logic [4:0] OP_NOP     = 5'h1f;
  localparam logic [4:0] OP_LOAD    = 5'h10;
  localparam logic [4:0] OP_MUL     = 5'h08;
  localparam int         MUL_CYCLES = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] IFID_R1_ADDR, IFID_R2_ADDR;
  logic [4:0] IDEX_OPCODE;
  logic [2:0] IDEX_RD_ADDR;
  logic [3:0] IDEX_R1_ADDR, IDEX_R2_ADDR;
  logic [2:0] EXMEM_RD_ADDR, MEMWB_RD_ADDR;
  logic       EXMEM_WE, MEMWB_WE, BR_TAKEN;
  logic       PC_STALL, IFID_STALL, IDEX_STALL;
  logic       IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MUL_DONE;
  logic [1:0] FWD_A, FWD_B;
`ifdef HAZ_STATS_EN
  logic [15:0] STALL_CNT, FLUSH_CNT;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Cycles the MUL currently in EX has already spent there; -1 when none.
  int mul_age = -1;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  hazard_ctrl #(
    .OP_NOP(OP_NOP), .OP_LOAD(OP_LOAD), .OP_MUL(OP_MUL), .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .IFID_R1_ADDR(IFID_R1_ADDR), .IFID_R2_ADDR(IFID_R2_ADDR),
    .IDEX_OPCODE(IDEX_OPCODE), .IDEX_RD_ADDR(IDEX_RD_ADDR),
    .IDEX_R1_ADDR(IDEX_R1_ADDR), .IDEX_R2_ADDR(IDEX_R2_ADDR),
    .EXMEM_RD_ADDR(EXMEM_RD_ADDR), .EXMEM_WE(EXMEM_WE),
    .MEMWB_RD_ADDR(MEMWB_RD_ADDR), .MEMWB_WE(MEMWB_WE),
    .BR_TAKEN(BR_TAKEN),
    .PC_STALL(PC_STALL), .IFID_STALL(IFID_STALL), .IDEX_STALL(IDEX_STALL),
    .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH), .EXMEM_FLUSH(EXMEM_FLUSH),
    .MUL_DONE(MUL_DONE), .FWD_A(FWD_A), .FWD_B(FWD_B)
`ifdef HAZ_STATS_EN
    , .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  function automatic logic [1:0] fwd_model(input logic [3:0] a,
                                           input logic ew, input logic [2:0] erd,
                                           input logic mw, input logic [2:0] mrd);
    if (a[3]) return 2'b00;
    if (ew && a[2:0] == erd) return 2'b01;
    if (mw && a[2:0] == mrd) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic reads_reg(input logic [3:0] src, input logic [2:0] rd);
    return (src[3] == 1'b0) && (src[2:0] == rd);
  endfunction

  // Per-cycle model compare; bits: PC,IFID_S,IDEX_S,IFID_F,IDEX_F,EXMEM_F,DONE,FWD_A,FWD_B.
  always @(negedge clk) begin : compare
    logic [10:0] want, got;
    logic        active;
    int          age;
    want   = '0;
    active = 1'b0;
    age    = 0;
    if (rst === 1'b1) begin
      want[3:2] = fwd_model(IDEX_R1_ADDR, EXMEM_WE, EXMEM_RD_ADDR, MEMWB_WE, MEMWB_RD_ADDR);
      want[1:0] = fwd_model(IDEX_R2_ADDR, EXMEM_WE, EXMEM_RD_ADDR, MEMWB_WE, MEMWB_RD_ADDR);
      if (mul_age >= 0) begin
        active = 1'b1;
        age    = mul_age;
      end else if (IDEX_OPCODE == OP_MUL) begin
        active = 1'b1;
        age    = 0;
      end
      if (BR_TAKEN) want[7:5] = 3'b111;
      else if (active) begin
        if (age == MUL_CYCLES - 1) want[4] = 1'b1;
        else begin
          want[10:8] = 3'b111;
          want[5]    = 1'b1;
        end
      end else if (IDEX_OPCODE == OP_LOAD &&
                   (reads_reg(IFID_R1_ADDR, IDEX_RD_ADDR) || reads_reg(IFID_R2_ADDR, IDEX_RD_ADDR))) begin
        want[10] = 1'b1;
        want[9]  = 1'b1;
        want[6]  = 1'b1;
      end
    end
    got = {PC_STALL, IFID_STALL, IDEX_STALL, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH,
           MUL_DONE, FWD_A, FWD_B};
    check("model_outputs", 32'(got), 32'(want));
`ifdef HAZ_STATS_EN
    check("model_stall_cnt", 32'(STALL_CNT), 32'(exp_stall_cnt));
    check("model_flush_cnt", 32'(FLUSH_CNT), 32'(exp_flush_cnt));
`endif
    // Advance the model to the state after the coming edge.
    if (rst !== 1'b1 || BR_TAKEN) mul_age = -1;
    else if (active) mul_age = (age == MUL_CYCLES - 1) ? -1 : age + 1;
    if (rst !== 1'b1) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (want[10] && exp_stall_cnt < 65535) exp_stall_cnt++;
      if (BR_TAKEN && exp_flush_cnt < 65535) exp_flush_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IFID_R1_ADDR  = 4'h8;
    IFID_R2_ADDR  = 4'h8;
    IDEX_OPCODE   = OP_NOP;
    IDEX_RD_ADDR  = 3'd0;
    IDEX_R1_ADDR  = 4'h8;
    IDEX_R2_ADDR  = 4'h8;
    EXMEM_RD_ADDR = 3'd0;
    EXMEM_WE      = 1'b0;
    MEMWB_RD_ADDR = 3'd0;
    MEMWB_WE      = 1'b0;
    BR_TAKEN      = 1'b0;
  endtask

  // Control-only literal check: {PC,IFID_S,IDEX_S,IFID_F,IDEX_F,EXMEM_F,DONE}.
  task automatic expect_ctl(input string name, input logic [6:0] want);
    @(negedge clk);
    check(name, 32'({PC_STALL, IFID_STALL, IDEX_STALL, IFID_FLUSH, IDEX_FLUSH,
                     EXMEM_FLUSH, MUL_DONE}), 32'(want));
  endtask

  initial begin
    bit prev_rst;
    int r;
    rst = 1'b0;
    idle();
    // Reset: hazard-provoking inputs must still leave every output at 0.
    IDEX_R1_ADDR  = 4'h2;
    EXMEM_WE      = 1'b1;
    EXMEM_RD_ADDR = 3'd2;
    BR_TAKEN      = 1'b1;
    IDEX_OPCODE   = OP_MUL;
    @(negedge clk);
    check("reset_all_zero", 32'({PC_STALL, IFID_STALL, IDEX_STALL, IFID_FLUSH, IDEX_FLUSH,
                                 EXMEM_FLUSH, MUL_DONE, FWD_A, FWD_B}), 32'd0);
    tick();
    idle();
    tick();
    rst = 1'b1;

    // T1 load-use: one-cycle stall and bubble, then clear.
    tick();
    IDEX_OPCODE  = OP_LOAD;
    IDEX_RD_ADDR = 3'd3;
    IFID_R1_ADDR = 4'h3;
    expect_ctl("t1_load_use", 7'b1100100);
    tick();
    IDEX_OPCODE = OP_NOP;
    expect_ctl("t1_after_bubble", 7'b0000000);

    // T2 immediate source never hazards.
    tick();
    IDEX_OPCODE  = OP_LOAD;
    IDEX_RD_ADDR = 3'd3;
    IFID_R1_ADDR = 4'hB;
    IFID_R2_ADDR = 4'h4;
    expect_ctl("t2_imm_no_stall", 7'b0000000);

    // T3 MUL holds EX for three cycles.
    tick();
    idle();
    IDEX_OPCODE = OP_MUL;
    expect_ctl("t3_mul_c1", 7'b1110010);
    tick();
    expect_ctl("t3_mul_c2", 7'b1110010);
    tick();
    expect_ctl("t3_mul_done", 7'b0000001);
    tick();
    IDEX_OPCODE = OP_NOP;
    expect_ctl("t3_after", 7'b0000000);

    // T4 branch kills a MUL entering EX, and one already waiting.
    tick();
    IDEX_OPCODE = OP_MUL;
    BR_TAKEN    = 1'b1;
    expect_ctl("t4_br_vs_mul", 7'b0001110);
    tick();
    BR_TAKEN    = 1'b0;
    IDEX_OPCODE = OP_NOP;
    expect_ctl("t4_after_br", 7'b0000000);
    tick();
    IDEX_OPCODE = OP_MUL;
    expect_ctl("t4b_mul_c1", 7'b1110010);
    tick();
    BR_TAKEN = 1'b1;
    expect_ctl("t4b_br_in_wait", 7'b0001110);
    tick();
    BR_TAKEN    = 1'b0;
    IDEX_OPCODE = OP_NOP;
    expect_ctl("t4b_no_done", 7'b0000000);

    // T5 forwarding priority and immediate operand.
    tick();
    idle();
    IDEX_R1_ADDR  = 4'h2;
    IDEX_R2_ADDR  = 4'hA;
    EXMEM_WE      = 1'b1;
    EXMEM_RD_ADDR = 3'd2;
    MEMWB_WE      = 1'b1;
    MEMWB_RD_ADDR = 3'd2;
    @(negedge clk);
    check("t5_fwd_a_exmem", 32'(FWD_A), 32'd1);
    check("t5_fwd_b_imm", 32'(FWD_B), 32'd0);
    tick();
    EXMEM_WE = 1'b0;
    @(negedge clk);
    check("t5_fwd_a_memwb", 32'(FWD_A), 32'd2);

    // T6 reset in MUL_WAIT aborts; MUL retriggers only when reissued.
    tick();
    idle();
    IDEX_OPCODE = OP_MUL;
    expect_ctl("t6_mul_c1", 7'b1110010);
    tick();
    rst = 1'b0;
    expect_ctl("t6_in_reset", 7'b0000000);
    tick();
    rst         = 1'b1;
    IDEX_OPCODE = OP_NOP;
    expect_ctl("t6_after_release", 7'b0000000);
    tick();
    IDEX_OPCODE = OP_MUL;
    expect_ctl("t6_retrigger", 7'b1110010);
    tick();
    tick();
    expect_ctl("t6_retrigger_done", 7'b0000001);
    tick();
    idle();

    // Randomized traffic, checked by the model every cycle.
    prev_rst = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      prev_rst = rst;
      if (rst == 1'b0) rst = ($urandom_range(0, 1) == 0);
      else             rst = ($urandom_range(0, 63) != 0);
      r = $urandom_range(0, 9);
      if (r < 2)      IDEX_OPCODE = OP_MUL;
      else if (r < 5) IDEX_OPCODE = OP_LOAD;
      else if (r < 7) IDEX_OPCODE = OP_NOP;
      else            IDEX_OPCODE = 5'($urandom);
      // Keep a fresh MUL out of EX on the first cycle after reset release.
      if (rst && !prev_rst && IDEX_OPCODE == OP_MUL) IDEX_OPCODE = OP_NOP;
      IDEX_RD_ADDR  = 3'($urandom_range(0, 3));
      IFID_R1_ADDR  = {1'($urandom), 3'($urandom_range(0, 3))};
      IFID_R2_ADDR  = {1'($urandom), 3'($urandom_range(0, 3))};
      IDEX_R1_ADDR  = {1'($urandom), 3'($urandom_range(0, 3))};
      IDEX_R2_ADDR  = {1'($urandom), 3'($urandom_range(0, 3))};
      EXMEM_RD_ADDR = 3'($urandom_range(0, 3));
      MEMWB_RD_ADDR = 3'($urandom_range(0, 3));
      EXMEM_WE      = 1'($urandom);
      MEMWB_WE      = 1'($urandom);
      BR_TAKEN      = ($urandom_range(0, 11) == 0);
    end
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
